// File: rtl/dram_ring_arbiter.sv
// Ring-buffer DRAM command arbiter: write-priority with a read starvation cap.
// Owns ring pointers, fill level, outstanding-read count and sticky overflow.
module dram_ring_arbiter #(
  parameter int          ADDR_W    = 24,
  parameter int          DEPTH     = 1024,
  parameter int unsigned BASE_ADDR = 0,
  parameter int          WR_BURST  = 8,
  parameter int          MAX_OUT   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_req,
  output logic                     wr_ack,
  input  logic                     rd_req,
  output logic                     rd_ack,
  output logic                     dram_cmd_valid,
  output logic                     dram_cmd_rnw,
  output logic [ADDR_W-1:0]        dram_addr,
  input  logic                     dram_cmd_ack,
  input  logic                     dram_rd_val,
  input  logic                     clr_ovf,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int FILL_W = PTR_W + 1;
  localparam int OUT_W  = $clog2(MAX_OUT + 1);
  localparam int STK_W  = $clog2(WR_BURST + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WR   = 2'd1;
  localparam logic [1:0] ST_RD   = 2'd2;

  logic [1:0]       state;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OUT_W-1:0] outstanding;
  logic [STK_W-1:0] wr_streak;
  logic             streak_inc;

  logic wr_el;
  logic rd_el;
  logic grant_rd;
  logic rd_accept;
  logic rd_val_eff;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full       = (fill_level == FILL_W'(DEPTH));
  assign empty      = (fill_level == '0);
  assign wr_el      = wr_req & ~full;
  assign rd_el      = rd_req & ~empty & (outstanding < OUT_W'(MAX_OUT));
  assign grant_rd   = rd_el & (~wr_el | (wr_streak >= STK_W'(WR_BURST)));
  assign rd_accept  = (state == ST_RD) & dram_cmd_ack;
  assign rd_val_eff = dram_rd_val & (outstanding != '0);

  // DRAM handshake: a command transfers on a cycle where dram_cmd_valid and
  // dram_cmd_ack are both high; valid, rnw and addr stay frozen until then.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= ST_IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fill_level     <= '0;
      outstanding    <= '0;
      wr_streak      <= '0;
      streak_inc     <= 1'b0;
      wr_ack         <= 1'b0;
      rd_ack         <= 1'b0;
      dram_cmd_valid <= 1'b0;
      dram_cmd_rnw   <= 1'b0;
      dram_addr      <= ADDR_W'(BASE_ADDR);
      overflow       <= 1'b0;
    end else begin
      wr_ack <= 1'b0;
      rd_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_rd) begin
            state          <= ST_RD;
            dram_cmd_valid <= 1'b1;
            dram_cmd_rnw   <= 1'b1;
            dram_addr      <= ADDR_W'(BASE_ADDR) + ADDR_W'(rd_ptr);
          end else if (wr_el) begin
            state          <= ST_WR;
            dram_cmd_valid <= 1'b1;
            dram_cmd_rnw   <= 1'b0;
            dram_addr      <= ADDR_W'(BASE_ADDR) + ADDR_W'(wr_ptr);
            streak_inc     <= rd_el;
          end
        end
        ST_WR: begin
          if (dram_cmd_ack) begin
            state          <= ST_IDLE;
            dram_cmd_valid <= 1'b0;
            wr_ack         <= 1'b1;
            wr_ptr         <= ptr_inc(wr_ptr);
            fill_level     <= fill_level + FILL_W'(1);
            // Streak only counts writes that actually made a read wait.
            if (streak_inc && (wr_streak < STK_W'(WR_BURST)))
              wr_streak <= wr_streak + STK_W'(1);
          end
        end
        ST_RD: begin
          if (dram_cmd_ack) begin
            state          <= ST_IDLE;
            dram_cmd_valid <= 1'b0;
            rd_ack         <= 1'b1;
            rd_ptr         <= ptr_inc(rd_ptr);
            fill_level     <= fill_level - FILL_W'(1);
            wr_streak      <= '0;
          end
        end
        default: begin
          state          <= ST_IDLE;
          dram_cmd_valid <= 1'b0;
        end
      endcase

      if (rd_accept && !rd_val_eff)
        outstanding <= outstanding + OUT_W'(1);
      else if (!rd_accept && rd_val_eff)
        outstanding <= outstanding - OUT_W'(1);

      overflow <= (wr_req & full) | (overflow & ~clr_ovf);
    end
  end

endmodule

// File: tb/tb_dram_ring_arbiter.sv
// Randomized bench for dram_ring_arbiter against a queue-based ring model;
// commands are checked in issue order, per-cycle status against tagged expectations.
module tb_dram_ring_arbiter;

  localparam int          ADDR_W    = 12;
  localparam int          DEPTH     = 4;
  localparam int unsigned BASE_ADDR = 32'h100;
  localparam int          WR_BURST  = 2;
  localparam int          MAX_OUT   = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   wr_req;
  logic                   wr_ack;
  logic                   rd_req;
  logic                   rd_ack;
  logic                   dram_cmd_valid;
  logic                   dram_cmd_rnw;
  logic [ADDR_W-1:0]      dram_addr;
  logic                   dram_cmd_ack;
  logic                   dram_rd_val;
  logic                   clr_ovf;
  logic [$clog2(DEPTH):0] fill_level;
  logic                   full;
  logic                   empty;
  logic                   overflow;

  dram_ring_arbiter #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR),
    .WR_BURST(WR_BURST), .MAX_OUT(MAX_OUT)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_ack(rd_ack),
    .dram_cmd_valid(dram_cmd_valid), .dram_cmd_rnw(dram_cmd_rnw),
    .dram_addr(dram_addr), .dram_cmd_ack(dram_cmd_ack),
    .dram_rd_val(dram_rd_val), .clr_ovf(clr_ovf),
    .fill_level(fill_level), .full(full), .empty(empty), .overflow(overflow)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard
  typedef struct {
    int cyc;
    int fill;
    bit ovf;
    bit valid;
    bit wack;
    bit rack;
    bit chk_addr;
    int addr;
  } st_t;

  logic [ADDR_W:0] exp_q[$];
  st_t             st_q[$];
  int              checks = 0;
  int              failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // reference model: ring contents as a queue of slot indices
  int ring_q[$];
  int wr_slot  = 0;
  int m_busy   = 0;   // 0 none, 1 write in flight, 2 read in flight
  int m_out    = 0;
  int m_streak = 0;
  bit m_inc    = 1'b0;
  bit m_ovf    = 1'b0;
  int m_addr   = 0;
  bit wr_pend  = 1'b0;
  bit rd_pend  = 1'b0;

  task automatic step(input bit r, input bit w, input bit rq, input bit a,
                      input bit v, input bit c);
    st_t s;
    bit  wel, rel, fullm, w_acc, r_acc, ovf_n;
    int  out_n;
    rst = r; wr_req = w; rd_req = rq; dram_cmd_ack = a; dram_rd_val = v; clr_ovf = c;
    w_acc = 1'b0; r_acc = 1'b0;
    s.cyc = cyc + 1; s.chk_addr = 1'b0; s.addr = 0; s.valid = 1'b0;
    if (!r) begin
      m_busy = 0; ring_q.delete(); wr_slot = 0; m_out = 0; m_streak = 0; m_ovf = 1'b0;
      s.chk_addr = 1'b1; s.addr = int'(BASE_ADDR);
    end else begin
      fullm = (ring_q.size() == DEPTH);
      ovf_n = (w && fullm) || (m_ovf && !c);
      out_n = m_out;
      if (m_busy == 2 && a) out_n++;
      if (v && m_out > 0) out_n--;
      wel = w && !fullm;
      rel = rq && (ring_q.size() > 0) && (m_out < MAX_OUT);
      if (m_busy == 0) begin
        if (rel && (!wel || m_streak >= WR_BURST)) begin
          m_busy = 2;
          m_addr = int'(BASE_ADDR) + ring_q[0];
          exp_q.push_back({1'b1, ADDR_W'(m_addr)});
        end else if (wel) begin
          m_busy = 1;
          m_inc  = rel;
          m_addr = int'(BASE_ADDR) + wr_slot;
          exp_q.push_back({1'b0, ADDR_W'(m_addr)});
        end
      end else if (a) begin
        if (m_busy == 1) begin
          w_acc = 1'b1;
          ring_q.push_back(wr_slot);
          wr_slot = (wr_slot + 1) % DEPTH;
          if (m_inc && m_streak < WR_BURST) m_streak++;
        end else begin
          r_acc = 1'b1;
          void'(ring_q.pop_front());
          m_streak = 0;
        end
        m_busy = 0;
      end
      m_ovf = ovf_n;
      m_out = out_n;
      s.valid    = (m_busy != 0);
      s.chk_addr = (m_busy != 0);
      s.addr     = m_addr;
    end
    s.fill = ring_q.size(); s.ovf = m_ovf; s.wack = w_acc; s.rack = r_acc;
    st_q.push_back(s);
    if (w_acc) wr_pend = 1'b0;
    if (r_acc) rd_pend = 1'b0;
  endtask

  // driver tasks
  task automatic cycle(input int pw, input int pr, input int pa, input int pv, input int pc);
    bit a, v, c;
    @(posedge clk); #1;
    if (!wr_pend && $urandom_range(99) < pw) wr_pend = 1'b1;
    if (!rd_pend && $urandom_range(99) < pr) rd_pend = 1'b1;
    a = ($urandom_range(99) < pa);
    v = ($urandom_range(99) < pv);
    if (m_out == 0 && m_busy == 2 && a) v = 1'b0;
    c = ($urandom_range(99) < pc);
    step(1'b1, wr_pend, rd_pend, a, v, c);
  endtask

  task automatic run_phase(input int n, input int pw, input int pr, input int pa,
                           input int pv, input int pc);
    for (int i = 0; i < n; i++) cycle(pw, pr, pa, pv, pc);
  endtask

  // monitor
  logic [ADDR_W:0] mon_e;
  st_t             mon_s;
  bit              prev_valid = 1'b0;

  always @(negedge clk) begin
    if (dram_cmd_valid === 1'b1 && !prev_valid) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL cmd_unexpected cyc=%0d actual rnw=%0b addr=%0h expected none",
                 cyc, dram_cmd_rnw, dram_addr);
      end else begin
        mon_e = exp_q.pop_front();
        check("cmd_rnw", 32'(dram_cmd_rnw), 32'(mon_e[ADDR_W]));
        check("cmd_addr", 32'(dram_addr), 32'(mon_e[ADDR_W-1:0]));
      end
    end
    prev_valid = (dram_cmd_valid === 1'b1);
    while (st_q.size() > 0 && st_q[0].cyc <= cyc) begin
      mon_s = st_q.pop_front();
      check("cmd_valid", 32'(dram_cmd_valid), 32'(mon_s.valid));
      check("wr_ack", 32'(wr_ack), 32'(mon_s.wack));
      check("rd_ack", 32'(rd_ack), 32'(mon_s.rack));
      check("fill_level", 32'(fill_level), 32'(mon_s.fill));
      check("full", 32'(full), 32'(mon_s.fill == DEPTH));
      check("empty", 32'(empty), 32'(mon_s.fill == 0));
      check("overflow", 32'(overflow), 32'(mon_s.ovf));
      if (mon_s.chk_addr) check("addr_hold", 32'(dram_addr), 32'(mon_s.addr));
    end
  end

  initial begin
    rst = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    dram_cmd_ack = 1'b0; dram_rd_val = 1'b0; clr_ovf = 1'b0;
    // reset held with both requests asserted
    repeat (2) begin @(posedge clk); #1; step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); end
    run_phase(40, 100, 0, 100, 0, 0);     // fill, wrap, full, overflow
    run_phase(20, 100, 0, 100, 0, 30);    // clear attempts while write held
    run_phase(60, 0, 100, 100, 40, 0);    // drain via reads
    run_phase(300, 100, 100, 100, 10, 0); // contention, outstanding cap
    run_phase(1500, 50, 50, 50, 30, 5);   // general mix
    run_phase(300, 60, 60, 10, 30, 5);    // heavy ack backpressure
    // reset while a command waits for acceptance
    for (int i = 0; i < 40 && m_busy == 0; i++) cycle(100, 100, 0, 0, 0);
    run_phase(4, 0, 0, 0, 0, 0);
    @(posedge clk); #1; step(1'b0, wr_pend, rd_pend, 1'b0, 1'b0, 1'b0);
    run_phase(400, 50, 50, 60, 30, 5);
    run_phase(60, 0, 0, 100, 100, 0);     // quiesce
    @(posedge clk); @(negedge clk); #1;
    check("cmd_queue_drained", 32'(exp_q.size()), 32'd0);
    check("status_queue_drained", 32'(st_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
